mem_tbus_arb: RTL and testbench

Two-requester arbiter between the load unit and the store-queue drain port for the single trinity-bus (tbus) channel into the dcache. It accepts one request at a time and registers its payload. It drives the payload to the dcache until the request is accepted, then tracks the outstanding operation until `operation_done`. Completion and read data go back to the owning requester. A load-side flush cancels an unissued load request and silently absorbs the completion of an already-issued one.

---
 rtl/mem_tbus_arb.sv | 156 +++++++++++++++
 tb/tb_mem_tbus_arb.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_tbus_arb.sv
// Round-robin arbiter between the load unit and the store-queue drain for the single tbus channel
// into the dcache. One transaction is outstanding at a time; a load flush cancels or absorbs the load.
module mem_tbus_arb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int OPT_W  = 2
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              ld_index_valid,
    output logic              ld_index_ready,
    input  logic [ADDR_W-1:0] ld_index,
    input  logic [DATA_W-1:0] ld_write_data,
    input  logic [DATA_W-1:0] ld_write_mask,
    input  logic [OPT_W-1:0]  ld_operation_type,
    output logic [DATA_W-1:0] ld_read_data,
    output logic              ld_operation_done,
    input  logic              ld_flush_valid,

    input  logic              st_index_valid,
    output logic              st_index_ready,
    input  logic [ADDR_W-1:0] st_index,
    input  logic [DATA_W-1:0] st_write_data,
    input  logic [DATA_W-1:0] st_write_mask,
    input  logic [OPT_W-1:0]  st_operation_type,
    output logic [DATA_W-1:0] st_read_data,
    output logic              st_operation_done,

    output logic              dc_index_valid,
    input  logic              dc_index_ready,
    output logic [ADDR_W-1:0] dc_index,
    output logic [DATA_W-1:0] dc_write_data,
    output logic [DATA_W-1:0] dc_write_mask,
    output logic [OPT_W-1:0]  dc_operation_type,
    input  logic [DATA_W-1:0] dc_read_data,
    input  logic              dc_operation_done,

    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    localparam logic OWN_LD = 1'b0;
    localparam logic OWN_ST = 1'b1;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] wmask_q, wmask_d;
    logic [OPT_W-1:0]  optype_q, optype_d;

    logic ld_elig;
    logic grant_ld;
    logic grant_st;
    logic ld_flush_own;
    logic in_idle;

    // A load being flushed this cycle is not a candidate; ties go to whoever did not win last.
    assign in_idle      = (state_q == S_IDLE);
    assign ld_elig      = ld_index_valid & ~ld_flush_valid;
    assign grant_ld     = reset_n & in_idle & ld_elig
                          & (~st_index_valid | (last_grant_q == OWN_ST));
    assign grant_st     = reset_n & in_idle & st_index_valid
                          & (~ld_elig | (last_grant_q == OWN_LD));
    assign ld_flush_own = ld_flush_valid & (owner_q == OWN_LD);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        drop_d       = drop_q;
        index_d      = index_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        optype_d     = optype_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ld | grant_st) begin
                    state_d      = S_REQ;
                    owner_d      = grant_st;
                    last_grant_d = grant_st;
                    drop_d       = 1'b0;
                    index_d      = grant_st ? st_index          : ld_index;
                    wdata_d      = grant_st ? st_write_data     : ld_write_data;
                    wmask_d      = grant_st ? st_write_mask     : ld_write_mask;
                    optype_d     = grant_st ? st_operation_type : ld_operation_type;
                end
            end
            S_REQ: begin
                // A request that fires in the flush cycle is already at the dcache: absorb its done.
                if (dc_index_ready) begin
                    state_d = S_WAIT;
                    drop_d  = ld_flush_own;
                end else if (ld_flush_own) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (dc_operation_done) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b0;
                end else if (ld_flush_own) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_LD;
            last_grant_q <= OWN_ST;
            drop_q       <= 1'b0;
            index_q      <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            optype_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            drop_q       <= drop_d;
            index_q      <= index_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            optype_q     <= optype_d;
        end
    end

    assign ld_index_ready    = grant_ld;
    assign st_index_ready    = grant_st;

    assign dc_index_valid    = (state_q == S_REQ);
    assign dc_index          = index_q;
    assign dc_write_data     = wdata_q;
    assign dc_write_mask     = wmask_q;
    assign dc_operation_type = optype_q;

    assign ld_operation_done = dc_operation_done & (state_q == S_WAIT) & (owner_q == OWN_LD) & ~drop_q;
    assign st_operation_done = dc_operation_done & (state_q == S_WAIT) & (owner_q == OWN_ST);
    assign ld_read_data      = dc_read_data;
    assign st_read_data      = dc_read_data;

    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_mem_tbus_arb.sv
// Bench for mem_tbus_arb: directed scenarios plus random traffic, checked against a
// transaction-level model of the arbitration and completion rules.
module tb_mem_tbus_arb;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int OPT_W  = 2;
    localparam logic [OPT_W-1:0] OP_READ  = 2'd0;
    localparam logic [OPT_W-1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic              clock;
    logic              reset_n;
    logic              ld_index_valid, ld_index_ready, ld_operation_done, ld_flush_valid;
    logic [ADDR_W-1:0] ld_index;
    logic [DATA_W-1:0] ld_write_data, ld_write_mask, ld_read_data;
    logic [OPT_W-1:0]  ld_operation_type;
    logic              st_index_valid, st_index_ready, st_operation_done;
    logic [ADDR_W-1:0] st_index;
    logic [DATA_W-1:0] st_write_data, st_write_mask, st_read_data;
    logic [OPT_W-1:0]  st_operation_type;
    logic              dc_index_valid, dc_index_ready, dc_operation_done;
    logic [ADDR_W-1:0] dc_index;
    logic [DATA_W-1:0] dc_write_data, dc_write_mask, dc_read_data;
    logic [OPT_W-1:0]  dc_operation_type;
    logic [1:0]        dbg_state;

    mem_tbus_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OPT_W(OPT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .ld_index_valid(ld_index_valid), .ld_index_ready(ld_index_ready), .ld_index(ld_index),
        .ld_write_data(ld_write_data), .ld_write_mask(ld_write_mask),
        .ld_operation_type(ld_operation_type), .ld_read_data(ld_read_data),
        .ld_operation_done(ld_operation_done), .ld_flush_valid(ld_flush_valid),
        .st_index_valid(st_index_valid), .st_index_ready(st_index_ready), .st_index(st_index),
        .st_write_data(st_write_data), .st_write_mask(st_write_mask),
        .st_operation_type(st_operation_type), .st_read_data(st_read_data),
        .st_operation_done(st_operation_done),
        .dc_index_valid(dc_index_valid), .dc_index_ready(dc_index_ready), .dc_index(dc_index),
        .dc_write_data(dc_write_data), .dc_write_mask(dc_write_mask),
        .dc_operation_type(dc_operation_type), .dc_read_data(dc_read_data),
        .dc_operation_done(dc_operation_done), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] wm;
        logic [OPT_W-1:0]  op;
    } req_t;

    req_t              exp_q[$];
    logic [ADDR_W-1:0] fire_log[$];
    req_t              m_req;
    bit                m_active, m_issued, m_cancel, m_owner, m_last;
    bit                allow_stray;
    logic [DATA_W-1:0] drv_rdata;
    int                checks, errors;
    logic [63:0]       tie_exp [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + per-cycle checks ----------------
    always @(negedge clock) begin : model
        bit ld_ok, g_ld, g_st, exp_ldd, exp_std;
        logic [1:0] exp_state;
        if (!reset_n) begin
            m_active = 0; m_issued = 0; m_cancel = 0; m_owner = 0; m_last = 1;
            exp_q.delete();
            chk("rst_ld_ready", ld_index_ready, 0);
            chk("rst_st_ready", st_index_ready, 0);
            chk("rst_dc_valid", dc_index_valid, 0);
            chk("rst_dc_index", dc_index, 0);
            chk("rst_ld_done", ld_operation_done, 0);
            chk("rst_st_done", st_operation_done, 0);
            chk("rst_state", dbg_state, ST_IDLE);
        end else begin
            ld_ok = ld_index_valid && !ld_flush_valid;
            g_ld = 0; g_st = 0;
            if (!m_active) begin
                if (ld_ok && st_index_valid) begin
                    if (m_last) g_ld = 1; else g_st = 1;
                end else if (ld_ok) g_ld = 1;
                else if (st_index_valid) g_st = 1;
            end
            exp_state = !m_active ? ST_IDLE : (!m_issued ? ST_REQ : ST_WAIT);
            chk("state", dbg_state, exp_state);
            chk("ld_ready", ld_index_ready, g_ld);
            chk("st_ready", st_index_ready, g_st);
            chk("dc_valid", dc_index_valid, m_active && !m_issued);
            if (m_active && !m_issued) begin
                chk("dc_index_hold", dc_index, m_req.idx);
                chk("dc_op_hold", dc_operation_type, m_req.op);
            end
            exp_ldd = dc_operation_done && m_active && m_issued && !m_owner && !m_cancel;
            exp_std = dc_operation_done && m_active && m_issued && m_owner;
            chk("ld_done", ld_operation_done, exp_ldd);
            chk("st_done", st_operation_done, exp_std);
            if (exp_ldd) chk("ld_rdata", ld_read_data, drv_rdata);
            if (exp_std) chk("st_rdata", st_read_data, drv_rdata);
            if (dc_operation_done && !allow_stray) chk("done_outside_wait", dbg_state, ST_WAIT);

            if (g_ld || g_st) begin
                m_active = 1; m_issued = 0; m_cancel = 0; m_owner = g_st; m_last = g_st;
                m_req = g_st ? '{st_index, st_write_data, st_write_mask, st_operation_type}
                             : '{ld_index, ld_write_data, ld_write_mask, ld_operation_type};
                exp_q.push_back(m_req);
            end else if (m_active && !m_issued) begin
                if (dc_index_ready) begin
                    m_issued = 1;
                    if (!m_owner && ld_flush_valid) m_cancel = 1;
                end else if (!m_owner && ld_flush_valid) begin
                    m_active = 0;
                    void'(exp_q.pop_front());
                end
            end else if (m_active) begin
                if (dc_operation_done) begin
                    m_active = 0; m_cancel = 0;
                end else if (!m_owner && ld_flush_valid) begin
                    m_cancel = 1;
                end
            end
        end
    end

    // ---------------- dcache-side monitor ----------------
    always @(negedge clock) begin : dc_mon
        req_t e;
        if (reset_n && dc_index_valid && dc_index_ready) begin
            fire_log.push_back(dc_index);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL dc_fire: got request %h, expected none", dc_index);
            end else begin
                e = exp_q.pop_front();
                chk("dc_index", dc_index, e.idx);
                chk("dc_wdata", dc_write_data, e.wd);
                chk("dc_wmask", dc_write_mask, e.wm);
                chk("dc_optype", dc_operation_type, e.op);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic clear_inputs();
        ld_index_valid = 0; ld_index = 0; ld_write_data = 0; ld_write_mask = 0;
        ld_operation_type = 0; ld_flush_valid = 0;
        st_index_valid = 0; st_index = 0; st_write_data = 0; st_write_mask = 0;
        st_operation_type = 0;
        dc_index_ready = 0; dc_read_data = 0; dc_operation_done = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        clear_inputs();
        repeat (3) tick();
        reset_n = 1;
        tick();
    endtask

    task automatic wait_ready(input bit is_st, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            if (is_st ? st_index_ready : ld_index_ready) ok = 1;
            else if (i < budget - 1) @(posedge clock);
        end
        tick();
    endtask

    task automatic wait_fire(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            if (dc_index_valid && dc_index_ready) ok = 1;
            else if (i < budget - 1) @(posedge clock);
        end
        tick();
    endtask

    task automatic pulse_done(input logic [63:0] d, output logic gl, output logic gs,
                              output logic [63:0] gdl, output logic [63:0] gds);
        dc_operation_done = 1; dc_read_data = d; drv_rdata = d;
        @(negedge clock);
        gl = ld_operation_done; gs = st_operation_done; gdl = ld_read_data; gds = st_read_data;
        tick();
        dc_operation_done = 0;
    endtask

    task automatic start_load(input logic [63:0] idx, input string tag);
        bit ok;
        ld_index_valid = 1; ld_index = idx; ld_operation_type = OP_READ;
        ld_write_data = 0; ld_write_mask = 0;
        wait_ready(0, 8, ok);
        chk({tag, "_grant"}, ok, 1);
        ld_index_valid = 0;
    endtask

    task automatic do_load(input logic [63:0] idx, input int rdy_delay,
                           input logic [63:0] rdata, input string tag);
        bit ok; logic gl, gs; logic [63:0] gdl, gds;
        start_load(idx, tag);
        repeat (rdy_delay) tick();
        dc_index_ready = 1;
        wait_fire(8, ok);
        chk({tag, "_fire"}, ok, 1);
        dc_index_ready = 0;
        pulse_done(rdata, gl, gs, gdl, gds);
        chk({tag, "_ld_done"}, gl, 1);
        chk({tag, "_st_done"}, gs, 0);
        chk({tag, "_rdata"}, gdl, rdata);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok, ld_fired, st_fired;
        logic gl, gs;
        logic [63:0] gdl, gds;
        checks = 0; errors = 0; allow_stray = 0; drv_rdata = 0;
        tie_exp[0] = 64'h100; tie_exp[1] = 64'h200; tie_exp[2] = 64'h100; tie_exp[3] = 64'h200;
        do_reset();

        // single load, dcache ready two cycles after the request appears
        do_load(64'h8000_0010, 2, 64'hDEAD_BEEF, "single");

        // tie after reset: load wins first, then strict alternation
        do_reset();
        fire_log.delete();
        ld_index_valid = 1; ld_index = 64'h100; ld_operation_type = OP_READ;
        st_index_valid = 1; st_index = 64'h200; st_operation_type = OP_WRITE;
        st_write_mask = 64'hFF; st_write_data = 64'h1234_5678_9ABC_DEF0;
        dc_index_ready = 1;
        for (int k = 0; k < 4; k++) begin
            wait_fire(8, ok);
            chk("tie_fire", ok, 1);
            pulse_done(64'h0, gl, gs, gdl, gds);
            chk("tie_done_owner", {gl, gs}, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        ld_index_valid = 0; st_index_valid = 0; dc_index_ready = 0;
        chk("tie_count", fire_log.size(), 4);
        for (int k = 0; k < 4; k++)
            chk("tie_order", (k < fire_log.size()) ? fire_log[k] : '1, tie_exp[k]);

        // flush while the load waits in REQ: request withdrawn, pending store granted next
        start_load(64'h3000, "flushreq");
        st_index_valid = 1; st_index = 64'h4000; st_operation_type = OP_WRITE;
        st_write_data = 64'hA5A5; st_write_mask = 64'h0F;
        ld_flush_valid = 1;
        tick();
        ld_flush_valid = 0;
        @(negedge clock);
        chk("flushreq_dc_valid", dc_index_valid, 0);
        chk("flushreq_st_grant", st_index_ready, 1);
        tick();
        st_index_valid = 0; dc_index_ready = 1;
        wait_fire(8, ok);
        chk("flushreq_st_fire", ok, 1);
        dc_index_ready = 0;
        pulse_done(64'h66, gl, gs, gdl, gds);
        chk("flushreq_ld_done", gl, 0);
        chk("flushreq_st_done", gs, 1);
        chk("flushreq_st_rdata", gds, 64'h66);

        // flush while the load waits in WAIT: completion absorbed
        start_load(64'h5000, "flushwait");
        dc_index_ready = 1;
        wait_fire(8, ok);
        chk("flushwait_fire", ok, 1);
        dc_index_ready = 0;
        ld_flush_valid = 1;
        tick();
        ld_flush_valid = 0;
        pulse_done(64'h55, gl, gs, gdl, gds);
        chk("flushwait_ld_done", gl, 0);
        chk("flushwait_st_done", gs, 0);
        @(negedge clock);
        chk("flushwait_idle", dbg_state, ST_IDLE);
        tick();
        do_load(64'h5008, 0, 64'hCAFE, "afterflush");

        // flush and dcache ready in the same cycle: the fire wins, done suppressed
        start_load(64'h6000, "flushfire");
        dc_index_ready = 1; ld_flush_valid = 1;
        tick();
        dc_index_ready = 0; ld_flush_valid = 0;
        @(negedge clock);
        chk("flushfire_wait", dbg_state, ST_WAIT);
        tick();
        pulse_done(64'h77, gl, gs, gdl, gds);
        chk("flushfire_ld_done", gl, 0);

        // asynchronous reset in the middle of WAIT
        start_load(64'h7000, "rstwait");
        dc_index_ready = 1;
        wait_fire(8, ok);
        chk("rstwait_fire", ok, 1);
        dc_index_ready = 0;
        #2 reset_n = 0;
        #1;
        chk("rstwait_dc_valid", dc_index_valid, 0);
        chk("rstwait_dc_index", dc_index, 0);
        chk("rstwait_dc_wdata", dc_write_data, 0);
        chk("rstwait_dc_wmask", dc_write_mask, 0);
        chk("rstwait_dc_op", dc_operation_type, 0);
        chk("rstwait_state", dbg_state, ST_IDLE);
        @(negedge clock);
        tick();
        reset_n = 1;
        allow_stray = 1;
        pulse_done(64'h99, gl, gs, gdl, gds);
        allow_stray = 0;
        chk("rstwait_stray_ld_done", gl, 0);
        chk("rstwait_stray_st_done", gs, 0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            ld_fired = ld_index_valid && ld_index_ready;
            st_fired = st_index_valid && st_index_ready;
            tick();
            if (ld_fired) ld_index_valid = 0;
            if (st_fired) st_index_valid = 0;
            if (!ld_index_valid && $urandom_range(0, 2) == 0) begin
                ld_index_valid = 1;
                ld_index = {$urandom, $urandom};
                ld_write_data = {$urandom, $urandom};
                ld_write_mask = {$urandom, $urandom};
                ld_operation_type = 2'($urandom_range(0, 3));
            end
            if (!st_index_valid && $urandom_range(0, 2) == 0) begin
                st_index_valid = 1;
                st_index = {$urandom, $urandom};
                st_write_data = {$urandom, $urandom};
                st_write_mask = {$urandom, $urandom};
                st_operation_type = 2'($urandom_range(0, 3));
            end
            ld_flush_valid = ($urandom_range(0, 9) == 0);
            dc_index_ready = 1'($urandom_range(0, 1));
            if (m_active && m_issued && $urandom_range(0, 2) == 0) begin
                dc_operation_done = 1;
                dc_read_data = {$urandom, $urandom};
                drv_rdata = dc_read_data;
            end else begin
                dc_operation_done = 0;
            end
        end
        clear_inputs();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
